// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg : shared SPI mode encodings, bit-count sizing and idle-word default
// Rev 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  localparam logic [31:0] SPI_TX_IDLE_DEFAULT = 32'h0000_0000;

  function automatic int spi_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_slave_param_if : SPI pins plus TX/RX handshake bundle for spi_slave_param
// Rev 1.0
// ---------------------------------------------------------------------------
interface spi_slave_param_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  sclk;
  logic                  mosi;
  logic                  cs_n;
  logic                  miso;
  logic                  miso_en;
  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_underrun;
  logic [WORD_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_abort;
  logic                  busy;

  modport slave (
    input  sclk, mosi, cs_n, tx_data, tx_valid,
    output miso, miso_en, tx_ready, tx_underrun, rx_data, rx_valid, frame_abort, busy
  );

  modport master (
    output sclk, mosi, cs_n, tx_data, tx_valid,
    input  miso, miso_en, tx_ready, tx_underrun, rx_data, rx_valid, frame_abort, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_sync_edge : multi-flop synchroniser with rise/fall detect on one input
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule
`default_nettype wire

// File: rtl/spi_slave_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_slave_param : oversampled SPI slave, any mode/width, valid/ready TX path
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 8,
  parameter bit                    CPOL        = 1'b0,
  parameter bit                    CPHA        = 1'b0,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [WORD_WIDTH-1:0] TX_IDLE     = WORD_WIDTH'(SPI_TX_IDLE_DEFAULT)
) (
  input wire               clk_sb,
  input wire               reset,
  spi_slave_param_if.slave bus
);

  localparam int              CNT_W   = spi_cnt_width(WORD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_WIDTH - 1);
  localparam spi_mode_e       MODE    = spi_mode_e'({CPOL, CPHA});
  localparam bit SAMPLE_ON_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

  localparam logic [1:0] ST_LOCKOUT = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .clk(clk_sb), .rst(reset), .i_async(bus.sclk),
    .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  // cs_n resets to "active" so a frame in flight at reset is never seen as a fresh cs_fall
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk(clk_sb), .rst(reset), .i_async(bus.cs_n),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  always_ff @(posedge clk_sb) begin
    if (reset) r_mosi_sync <= '0;
    else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  logic [1:0] r_state, w_state_next;
  logic       w_frame_start, w_in_frame, w_frame_end, w_busy;

  always_ff @(posedge clk_sb) begin
    if (reset) r_state <= ST_LOCKOUT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOCKOUT: if (w_cs_sync) w_state_next = ST_IDLE;
      ST_IDLE:    if (w_cs_fall) w_state_next = ST_ACTIVE;
      ST_ACTIVE:  if (w_cs_rise) w_state_next = ST_IDLE;
      default:    w_state_next = ST_LOCKOUT;
    endcase
  end

  always_comb begin
    w_frame_start = (r_state == ST_IDLE) & w_cs_fall;
    w_in_frame    = (r_state == ST_ACTIVE) & ~w_cs_sync;
    w_frame_end   = (r_state == ST_ACTIVE) & w_cs_rise;
    w_busy        = w_frame_start | w_in_frame;
  end

  logic w_sclk_edge, w_lead, w_trail, w_sample, w_shift, w_word_start;
  logic [CNT_W-1:0] r_cnt;
  logic             r_word_done;
  logic             w_cnt_zero;

  assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
  assign w_lead      = w_sclk_edge & (w_sclk_sync != CPOL);
  assign w_trail     = w_sclk_edge & (w_sclk_sync == CPOL);
  assign w_sample    = w_in_frame & (SAMPLE_ON_LEAD ? w_lead : w_trail);
  assign w_shift     = w_in_frame & (SAMPLE_ON_LEAD ? w_trail : w_lead);
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_word_start = SAMPLE_ON_LEAD
                      ? (w_frame_start | (w_shift & w_cnt_zero & r_word_done))
                      : (w_shift & w_cnt_zero);

  logic [WORD_WIDTH-1:0] r_rx_shift, r_rx_data, w_rx_shift_next;
  logic                  r_rx_done, r_rx_valid, r_frame_abort, r_miso_en;

  assign w_rx_shift_next = MSB_FIRST ? {r_rx_shift[WORD_WIDTH-2:0], w_mosi}
                                     : {w_mosi, r_rx_shift[WORD_WIDTH-1:1]};

  always_ff @(posedge clk_sb) begin
    if (reset) begin
      r_cnt         <= '0;
      r_word_done   <= 1'b0;
      r_rx_shift    <= '0;
      r_rx_done     <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_abort <= 1'b0;
      r_miso_en     <= 1'b0;
    end else begin
      r_rx_done     <= 1'b0;
      r_rx_valid    <= r_rx_done;
      r_frame_abort <= 1'b0;
      r_miso_en     <= w_busy;
      if (r_rx_done) r_rx_data <= r_rx_shift;
      if (w_frame_end) begin
        r_cnt         <= '0;
        r_word_done   <= 1'b0;
        r_frame_abort <= ~w_cnt_zero;
      end else if (w_sample) begin
        r_rx_shift <= w_rx_shift_next;
        if (r_cnt == CNT_MAX) begin
          r_cnt       <= '0;
          r_rx_done   <= 1'b1;
          r_word_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  logic [WORD_WIDTH-1:0] r_hold, r_tx_shift, w_load_word, w_load_rest, w_next_rest;
  logic                  r_hold_full, r_miso, r_tx_underrun, w_accept;
  logic                  w_load_first, w_next_bit;

  // A word starting in the same cycle as an accept sees the pre-accept holding state
  assign w_accept     = bus.tx_valid & ~r_hold_full;
  assign w_load_word  = r_hold_full ? r_hold : TX_IDLE;
  assign w_load_first = MSB_FIRST ? w_load_word[WORD_WIDTH-1] : w_load_word[0];
  assign w_load_rest  = MSB_FIRST ? {w_load_word[WORD_WIDTH-2:0], 1'b0}
                                  : {1'b0, w_load_word[WORD_WIDTH-1:1]};
  assign w_next_bit   = MSB_FIRST ? r_tx_shift[WORD_WIDTH-1] : r_tx_shift[0];
  assign w_next_rest  = MSB_FIRST ? {r_tx_shift[WORD_WIDTH-2:0], 1'b0}
                                  : {1'b0, r_tx_shift[WORD_WIDTH-1:1]};

  always_ff @(posedge clk_sb) begin
    if (reset) begin
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_tx_shift    <= '0;
      r_miso        <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_underrun <= 1'b0;
      if (w_word_start) begin
        r_miso        <= w_load_first;
        r_tx_shift    <= w_load_rest;
        r_tx_underrun <= ~r_hold_full;
      end else if (w_shift) begin
        r_miso     <= w_next_bit;
        r_tx_shift <= w_next_rest;
      end
      if (w_word_start && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold      <= bus.tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign bus.miso        = r_miso;
  assign bus.miso_en     = r_miso_en;
  assign bus.tx_ready    = ~r_hold_full;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.frame_abort = r_frame_abort;
  assign bus.busy        = w_busy;

endmodule
`default_nettype wire

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised successor to the fixed 8-bit, mode-0 SPI slave. Supports configurable word width, all four CPOL/CPHA modes and MSB/LSB-first ordering.
- Receives back-to-back words within one chip-select frame and uses a valid/ready TX handshake with a holding register. Flags underrun and aborted frames.
- Oversamples SCLK, MOSI and CS_N in the system clock domain. Sits between the external SPI pins (MISO via open-drain pad with miso_en) and the matrix register/command logic.

Parameters:
WORD_WIDTH, 8, bits per SPI word (2..32)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge / shift on trailing; 1 = shift on leading / sample on trailing
MSB_FIRST, 1, 1 = MSB first on both MOSI and MISO; 0 = LSB first
SYNC_STAGES, 2, synchroniser depth on sclk/mosi/cs_n (>=2)
TX_IDLE, 0, word sent when the holding register is empty at word start

Ports:
clk_sb  in  1  system clock; only clock; must be >= 8x SCLK
reset  in  1  synchronous, active-high reset
sclk  in  1  SPI clock (asynchronous)
mosi  in  1  SPI data in (asynchronous)
cs_n  in  1  SPI chip select, active low (asynchronous)
miso  out  1  SPI data out
miso_en  out  1  output enable for open-drain pad
tx_data  in  WORD_WIDTH  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty
tx_underrun  out  1  1-cycle pulse: word started with empty holding register
rx_data  out  WORD_WIDTH  last received word
rx_valid  out  1  1-cycle pulse: rx_data updated
frame_abort  out  1  1-cycle pulse: cs_n released with a partial word
busy  out  1  synchronised chip select active

Behaviour:
- Clock and reset: one clock, clk_sb; reset is synchronous and active-high (reset). All state updates on the rising edge of clk_sb.
- Reset values: miso=0, miso_en=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0, busy=0, bit count=0, holding register empty.
- Reset mid-frame: all state is discarded. The block ignores the rest of the frame until cs_n has been seen high at least once.
- Input synchronisation:
  - sclk, mosi and cs_n each pass through SYNC_STAGES flops, plus one history flop.
  - lead = synced sclk leaves CPOL; trail = synced sclk returns to CPOL.
  - sample_edge = lead if CPHA=0, else trail. shift_edge = trail if CPHA=0, else lead.
  - Edges are ignored while synced cs_n is high.
- busy: equals NOT synced cs_n. cs_fall and cs_rise are edge detects on synced cs_n.
- RX path:
  - On sample_edge, shift synced mosi into the RX shift register; direction per MSB_FIRST.
  - Bit count increments modulo WORD_WIDTH.
  - When the count wraps to 0, the next cycle has rx_data = assembled word and rx_valid = 1 for exactly one cycle.
  - Latency: rx_valid rises SYNC_STAGES+2 clk_sb cycles after the final sampling edge at the pin.
- Word-start event (load TX shift register):
  - CPHA=0: cs_fall, and any shift_edge with bit count 0 after at least one completed word.
  - CPHA=1: any shift_edge with bit count 0.
  - If the holding register is full: load from it, set tx_ready=1.
  - If it is empty: load TX_IDLE and pulse tx_underrun.
- MISO output:
  - At word start, miso presents the first bit immediately (MSB if MSB_FIRST).
  - On other shift_edges, miso presents the next bit.
  - miso_en = busy, registered. miso holds its value while cs_n is high.
- TX handshake:
  - tx_valid && tx_ready loads the holding register; tx_ready falls the next cycle.
  - Same-cycle accept and word-start: the shift register takes the old holding state (TX_IDLE plus underrun if empty). The new word is kept for the next word.
  - tx_valid while not ready is ignored; the producer holds the data.
- Frame end (cs_rise):
  - Bit count resets to 0. The holding register is retained.
  - If bit count != 0: pulse frame_abort, discard the partial RX word, no rx_valid.
  - Bit count == 0 gives a clean end with no pulse.
- Simultaneous cs_rise and sample_edge: the sample is ignored; cs_rise has priority.

Decomposition:
- Package spi_pkg: mode encodings (SPI_MODE0..3 as {CPOL,CPHA}), clog2-based bit-count width function, default TX_IDLE constant.
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall detect for one signal. Instantiated for sclk and cs_n; mosi uses the synchroniser only.

Test Plan:
- Mode 0, W=8, MSB: cs low, send 0xA5 with tx preloaded 0x3C -> rx_valid once, rx_data=0xA5; MISO bits 0,0,1,1,1,1,0,0; tx_ready=1 after cs_fall.
- Mode 3, W=16, LSB-first, two back-to-back words 0x1234, 0xBEEF in one frame -> two rx_valid pulses with those values; MISO LSB-first per word.
- Holding register empty at second word start (TX_IDLE=0xFF) -> tx_underrun pulse once; MISO sends 0xFF.
- cs_n released after 5 of 8 bits -> frame_abort pulse; no rx_valid; next frame 0x81 received correctly.
- Reset asserted mid-word, released with cs still low -> outputs at reset values; no rx_valid until cs high then low.
- Accept tx_valid in the same cycle as word start -> current word TX_IDLE plus underrun; next word carries the accepted data.
